// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, WAIT_STATES wait cycles, then a word access and a response.
// Optional byte-strobe writes when DMEM_BYTE_STRB_EN is defined.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    logic [31:0] mem [DEPTH_WORDS];

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic          do_access;
    logic          mem_we;

`ifdef DMEM_BYTE_STRB_EN
    logic [3:0]    wstrb_q, wstrb_d;
    logic [3:0]    acc_wstrb;
`else
    logic          unused_wstrb;
    assign unused_wstrb = ^req_wstrb_i;
`endif

    // With zero wait states the access happens on the accepting edge, so use the live request.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
`ifdef DMEM_BYTE_STRB_EN
        acc_wstrb = wstrb_q;
`endif
        if (state_q == S_IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
`ifdef DMEM_BYTE_STRB_EN
            acc_wstrb = req_wstrb_i;
`endif
        end
        acc_idx = acc_addr[AW+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef DMEM_BYTE_STRB_EN
        wstrb_d     = wstrb_q;
`endif
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        do_access   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
`ifdef DMEM_BYTE_STRB_EN
                    wstrb_d = req_wstrb_i;
`endif
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CW'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // Reset on the access edge abandons the store.
    assign mem_we = do_access && acc_we && !acc_err && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
`ifdef DMEM_BYTE_STRB_EN
            wstrb_q     <= 4'd0;
`endif
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef DMEM_BYTE_STRB_EN
            wstrb_q     <= wstrb_d;
`endif
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Word array; never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
`ifdef DMEM_BYTE_STRB_EN
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
`else
            mem[acc_idx] <= acc_wdata;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b0;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic [3:0]  req_wstrb0 = '0;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp2, exp3;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
        .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_wstrb_i(req_wstrb0),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
        .rsp_err_o(rsp_err0), .busy_o(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the WAIT_STATES=2 instance, with latency check.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rdata_clr"}, rsp_rdata, 32'd0);
        chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst0.ready", 32'(req_ready0), 32'd1);

        // Full-word store then load
        txn("t1.st", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        txn("t1.ld", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Partial strobe, then all-zero strobe
`ifdef DMEM_BYTE_STRB_EN
        exp2 = 32'hDEADAAEF;
        exp3 = 32'hDEADAAEF;
`else
        exp2 = 32'h0000AA00;
        exp3 = 32'h11111111;
`endif
        txn("t2.st", 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'd0, 1'b0);
        txn("t2.ld", 1'b0, 32'h10, 32'd0, 4'h0, exp2, 1'b0);
        txn("t2.st0", 1'b1, 32'h10, 32'h11111111, 4'b0000, 32'd0, 1'b0);
        txn("t2.ld0", 1'b0, 32'h10, 32'd0, 4'h0, exp3, 1'b0);

        // Errors and top-of-array boundary
        txn("t3.st0", 1'b1, 32'h0, 32'h12345678, 4'hF, 32'd0, 1'b0);
        txn("t3.mis", 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1);
        txn("t3.oor", 1'b1, 32'h1000, 32'h1, 4'hF, 32'd0, 1'b1);
        txn("t3.ld0", 1'b0, 32'h0, 32'd0, 4'h0, 32'h12345678, 1'b0);
        txn("t3.sttop", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
        txn("t3.ldtop", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);
        txn("t3.ld0b", 1'b0, 32'h0, 32'd0, 4'h0, 32'h12345678, 1'b0);

        // Backpressure in RESP with a competing request
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4.valid", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77; req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4.hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4.hold_rdata", rsp_rdata, exp3);
            chk("t4.hold_err", 32'(rsp_err), 32'd0);
            chk("t4.hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t4.hs_valid", 32'(rsp_valid), 32'd0);
        chk("t4.hs_ready", 32'(req_ready), 32'd1);
        chk("t4.hs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4.acc_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("t4.st_valid", 32'(rsp_valid), 32'd1);
        chk("t4.st_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        txn("t4.ld", 1'b0, 32'h30, 32'd0, 4'h0, 32'h77, 1'b0);

        // Reset on the edge where a waiting store would commit
        txn("t5.pre", 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5.busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5.valid", 32'(rsp_valid), 32'd0);
        chk("t5.ready", 32'(req_ready), 32'd1);
        chk("t5.busy_clr", 32'(busy), 32'd0);
        txn("t5.ld", 1'b0, 32'h20, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);

        // Zero wait states, back-to-back requests
        @(negedge clk);
        rsp_ready0 = 1'b1; req_valid0 = 1'b1; req_we0 = 1'b1;
        req_addr0 = 32'h4; req_wdata0 = 32'h99; req_wstrb0 = 4'hF;
        for (int k = 0; k < 6; k++) begin
            chk("t6.ready", 32'(req_ready0), 32'((k % 2) == 0));
            chk("t6.valid", 32'(rsp_valid0), 32'((k % 2) == 1));
            if (k == 1) begin
                chk("t6.st_rdata", rsp_rdata0, 32'd0);
                req_we0 = 1'b0;
            end
            if (k == 3) chk("t6.ld_rdata", rsp_rdata0, 32'h99);
            @(negedge clk);
        end
        req_valid0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
